// File: rtl/ela_field_source_if.sv
// Pixel-source bus: row request, frame-memory read port and pixel stream.
interface ela_field_source_if;
    logic       req;
    logic       mem_rd;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       row_done;
    logic       field_done;
    logic       ovr;

    // Row server side
    modport master (
        input  req, mem_data,
        output mem_rd, mem_addr, pix_data, pix_valid, row_done, field_done, ovr
    );

    // Requester / memory side
    modport slave (
        output req, mem_data,
        input  mem_rd, mem_addr, pix_data, pix_valid, row_done, field_done, ovr
    );
endinterface

// File: rtl/ela_field_source.sv
// Field row server: on each req, reads one frame row (even or odd rows only)
// from memory and streams it as one pixel per cycle.
module ela_field_source #(
    parameter int WIDTH     = 32,
    parameter int ROWS      = 31,
    parameter int FIELD_ODD = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    ela_field_source_if.master     bus
);
    localparam int NROWS = (ROWS - FIELD_ODD + 1) / 2;
    localparam int AW    = 10;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int FW    = (NROWS > 1) ? $clog2(NROWS) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t          state, state_n;
    logic [FW-1:0]   fr, fr_n;
    logic [CW-1:0]   col, col_n, col_inc;
    logic            rd_n, row_done_n, rd_d1;
    logic [AW-1:0]   addr_n, row_base;

    // Start address of the frame row backing field row fr
    assign row_base = (AW'(fr) * AW'(2) + AW'(FIELD_ODD)) * AW'(WIDTH);
    assign col_inc  = col + CW'(1);

    // Next state; mem_rd/mem_addr are computed one cycle ahead so they register cleanly
    always_comb begin
        state_n    = state;
        fr_n       = fr;
        col_n      = col;
        rd_n       = 1'b0;
        addr_n     = bus.mem_addr;
        row_done_n = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_n = FETCH;
                    col_n   = '0;
                    rd_n    = 1'b1;
                    addr_n  = row_base;
                end
            end
            FETCH: begin
                if (col == CW'(WIDTH - 1)) begin
                    state_n = DRAIN;
                    col_n   = '0;
                end else begin
                    col_n  = col_inc;
                    rd_n   = 1'b1;
                    addr_n = row_base + AW'(col_inc);
                end
            end
            DRAIN: begin
                // Two cycles: last read returns, then lands in pix_data
                if (col == CW'(1)) begin
                    row_done_n = 1'b1;
                    col_n      = '0;
                    if (fr == FW'(NROWS - 1)) begin
                        state_n = DONE;
                    end else begin
                        state_n = IDLE;
                        fr_n    = fr + FW'(1);
                    end
                end else begin
                    col_n = col_inc;
                end
            end
            default: ;
        endcase
    end

    // Control state and registered bus outputs; reset abandons any row in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            fr             <= '0;
            col            <= '0;
            rd_d1          <= 1'b0;
            bus.mem_rd     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.pix_data   <= '0;
            bus.pix_valid  <= 1'b0;
            bus.row_done   <= 1'b0;
            bus.field_done <= 1'b0;
            bus.ovr        <= 1'b0;
        end else begin
            state          <= state_n;
            fr             <= fr_n;
            col            <= col_n;
            bus.mem_rd     <= rd_n;
            bus.mem_addr   <= addr_n;
            bus.row_done   <= row_done_n;
            // Read data arrives the cycle after the strobe; register it with its qualifier
            rd_d1          <= bus.mem_rd;
            bus.pix_valid  <= rd_d1;
            bus.pix_data   <= rd_d1 ? bus.mem_data : 8'h00;
            bus.field_done <= bus.field_done | (state == DONE);
            bus.ovr        <= bus.ovr | (bus.req && state != IDLE);
        end
    end
endmodule
